// File: rtl/stream_resize_pkg.sv
// -----------------------------------------------------------------------------
// stream_resize_pkg
//   Shared definitions for the stream width-resize stages.
//   - hs_e / hs_status : names the state of one valid/ready interface in a
//                        cycle, so every resize stage spells "transfer" the
//                        same way.
//   - keep_mask        : lane-keep mask with lanes 0..cnt set, clipped to the
//                        number of lanes actually present.
// -----------------------------------------------------------------------------
package stream_resize_pkg;

    // Widest lane count keep_mask can describe; callers cast down to RATIO.
    localparam int MAX_LANES = 64;

    // Handshake status of one valid/ready interface in the current cycle.
    typedef enum logic [1:0] {
        HS_IDLE  = 2'b00,   // no valid word offered
        HS_STALL = 2'b01,   // word offered, receiver not ready
        HS_XFER  = 2'b11    // word offered and taken on this clock edge
    } hs_e;

    function automatic hs_e hs_status(input logic valid, input logic ready);
        hs_e st;
        if (valid && ready) begin
            st = HS_XFER;
        end else if (valid) begin
            st = HS_STALL;
        end else begin
            st = HS_IDLE;
        end
        return st;
    endfunction

    // Lanes 0..cnt set, lanes at or above ratio never set.
    function automatic logic [MAX_LANES-1:0] keep_mask(input int cnt, input int ratio);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if ((i <= cnt) && (i < ratio)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/stream_upsize.sv
// -----------------------------------------------------------------------------
// stream_upsize
//   Packs RATIO narrow words from a valid/ready input stream into one wide
//   output beat, little-endian (first word of a beat lands in lane 0).
//   A word flagged last closes the beat early; m_keep_o marks filled lanes and
//   unfilled lanes read as zero.
//
// Handshake: a word/beat moves on a rising clk edge where valid and ready are
//   both high. A source holds valid and its payload stable until that edge;
//   ready may rise or fall freely. s_ready_o depends only on registered state,
//   m_ready_i and rst_n, never on the s_* payload or s_valid_i.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_data_i/_last_i    narrow input word and end-of-packet flag
//   s_valid_i/s_ready_o input handshake
//   m_data_o            packed beat, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   m_keep_o            bit k set = lane k holds a word
//   m_last_o            beat ends a packet
//   m_valid_o/m_ready_i output handshake
// -----------------------------------------------------------------------------
module stream_upsize
    import stream_resize_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int RATIO      = 4,
    localparam int CNT_WIDTH  = $clog2(RATIO) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       s_data_i,
    input  logic                        s_last_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    output logic [DATA_WIDTH*RATIO-1:0] m_data_o,
    output logic [RATIO-1:0]            m_keep_o,
    output logic                        m_last_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i
);

    logic [CNT_WIDTH-1:0]        cnt;
    logic [DATA_WIDTH*RATIO-1:0] acc;
    logic [DATA_WIDTH*RATIO-1:0] merged;
    logic                        s_xfer;
    logic                        m_xfer;
    logic                        complete;

    always_comb begin
        // The output register can take a new beat when empty or draining now.
        s_ready_o = rst_n & (~m_valid_o | m_ready_i);
        s_xfer    = (hs_status(s_valid_i, s_ready_o) == HS_XFER);
        m_xfer    = (hs_status(m_valid_o, m_ready_i) == HS_XFER);
        complete  = s_last_i | (cnt == CNT_WIDTH'(RATIO - 1));

        // Accumulator with the incoming word dropped into lane cnt. Lanes above
        // cnt are still zero because the accumulator clears after every beat.
        merged = acc;
        merged[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] = s_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            m_data_o  <= '0;
            m_keep_o  <= '0;
            m_last_o  <= 1'b0;
            m_valid_o <= 1'b0;
        end else begin
            if (m_xfer) begin
                m_valid_o <= 1'b0;
            end
            if (s_xfer) begin
                if (complete) begin
                    // Reload the output register; overrides the clear above so a
                    // drain and a reload on the same edge leave no bubble.
                    m_data_o  <= merged;
                    m_keep_o  <= RATIO'(keep_mask(int'(cnt), RATIO));
                    m_last_o  <= s_last_i;
                    m_valid_o <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= merged;
                    cnt <= cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_upsize.sv
// -----------------------------------------------------------------------------
// tb_stream_upsize
//   Directed bench for stream_upsize: one RATIO=4 instance and one RATIO=1
//   instance. Drivers update the bench's own packing model when a word is
//   accepted; the model pushes expected beats to a queue and a negedge monitor
//   pops and compares each beat as it is handed downstream.
// -----------------------------------------------------------------------------
module tb_stream_upsize;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT, RATIO = 4 ----------------
    logic [7:0]  s_data;
    logic        s_last, s_valid, s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last, m_valid, m_ready;

    stream_upsize #(.DATA_WIDTH(8), .RATIO(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data), .s_last_i(s_last), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_keep_o(m_keep), .m_last_o(m_last),
        .m_valid_o(m_valid), .m_ready_i(m_ready)
    );

    // ---------------- DUT, RATIO = 1 ----------------
    logic [7:0] s1_data;
    logic       s1_last, s1_valid, s1_ready;
    logic [7:0] m1_data;
    logic [0:0] m1_keep;
    logic       m1_last, m1_valid, m1_ready;

    stream_upsize #(.DATA_WIDTH(8), .RATIO(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s1_data), .s_last_i(s1_last), .s_valid_i(s1_valid), .s_ready_o(s1_ready),
        .m_data_o(m1_data), .m_keep_o(m1_keep), .m_last_o(m1_last),
        .m_valid_o(m1_valid), .m_ready_i(m1_ready)
    );

    // ---------------- scoreboard ----------------
    int vectors    = 0;
    int miscompares = 0;

    logic [36:0] exp_q[$];    // {last, keep[3:0], data[31:0]}
    logic [9:0]  exp1_q[$];   // {last, keep[0], data[7:0]}

    logic [31:0] mdl_acc = '0;
    int          mdl_cnt = 0;

    logic phase3 = 1'b0;
    int   ready_drops = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packing model for the RATIO=4 instance; returns 1 when a beat closes.
    function automatic logic model_accept(input logic [7:0] d, input logic l);
        logic [3:0] k;
        mdl_acc[mdl_cnt*8 +: 8] = d;
        if (mdl_cnt == 3 || l) begin
            k = 4'((1 << (mdl_cnt + 1)) - 1);
            exp_q.push_back({l, k, mdl_acc});
            mdl_acc = '0;
            mdl_cnt = 0;
            return 1'b1;
        end
        mdl_cnt++;
        return 1'b0;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat4", {32'h0, m_data}, 64'hDEAD);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("beat4_data", m_data, e[31:0]);
                chk("beat4_keep", m_keep, e[35:32]);
                chk("beat4_last", m_last, e[36]);
            end
        end
        if (phase3 && !s_ready) ready_drops++;
    end

    always @(negedge clk) begin
        if (rst_n && m1_valid && m1_ready) begin
            if (exp1_q.size() == 0) begin
                chk("unexpected_beat1", m1_data, 64'hDEAD);
            end else begin
                logic [9:0] e;
                e = exp1_q.pop_front();
                chk("beat1_data", m1_data, e[7:0]);
                chk("beat1_keep", m1_keep, e[8]);
                chk("beat1_last", m1_last, e[9]);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [7:0] d, input logic l);
        logic ok;
        int   waited;
        ok = 1'b0;
        waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!ok) begin
            chk("send4_timeout", 64'd0, 64'd1);
        end else if (model_accept(d, l)) begin
            chk("beat4_latency", m_valid, 1'b1);
        end
    endtask

    task automatic send1(input logic [7:0] d, input logic l);
        logic ok;
        int   waited;
        ok = 1'b0;
        waited = 0;
        s1_valid = 1'b1;
        s1_data  = d;
        s1_last  = l;
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = s1_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        s1_valid = 1'b0;
        s1_last  = 1'b0;
        if (!ok) begin
            chk("send1_timeout", 64'd0, 64'd1);
        end else begin
            exp1_q.push_back({l, 1'b1, d});
            chk("beat1_latency", m1_valid, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        s_data = '0; s_last = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        s1_data = '0; s1_last = 1'b0; s1_valid = 1'b0; m1_ready = 1'b1;
        idle(3);

        // Reset state: everything cleared, no input acceptance even with m_ready high.
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data",  m_data, 32'h0);
        chk("rst_m_keep",  m_keep, 4'h0);
        chk("rst_m_last",  m_last, 1'b0);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_s1_ready", s1_ready, 1'b0);
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_s_ready", s_ready, 1'b1);

        // 1: full packet, one beat with last.
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        idle(2);

        // 2: short packets, early flush.
        send(8'hA1, 1'b0); send(8'hA2, 1'b1);
        send(8'h5C, 1'b1);
        idle(2);

        // 3: streaming without last, ready never drops.
        phase3 = 1'b1;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        idle(3);
        phase3 = 1'b0;
        chk("t3_ready_drops", ready_drops, 0);

        // 4: backpressure holds the first beat and blocks input.
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h09;
        repeat (3) begin
            @(negedge clk);
            chk("t4_s_ready_low", s_ready, 1'b0);
            chk("t4_hold_valid",  m_valid, 1'b1);
            chk("t4_hold_data",   m_data, 32'h04030201);
            chk("t4_hold_keep",   m_keep, 4'hF);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        for (int i = 9; i <= 12; i++) send(8'(i), 1'b0);
        idle(3);

        // 5: reset mid-packet discards the partial beat.
        send(8'h21, 1'b0); send(8'h22, 1'b0);
        rst_n = 1'b0;
        idle(1);
        mdl_acc = '0;
        mdl_cnt = 0;
        chk("t5_rst_valid", m_valid, 1'b0);
        chk("t5_rst_ready", s_ready, 1'b0);
        rst_n = 1'b1;
        idle(1);
        send(8'h31, 1'b0); send(8'h32, 1'b0); send(8'h33, 1'b0); send(8'h34, 1'b0);
        idle(3);

        // 6: RATIO=1 registered pass-through.
        send1(8'h7E, 1'b0);
        send1(8'h7F, 1'b1);
        idle(4);

        chk("exp_q_drained",  exp_q.size(), 0);
        chk("exp1_q_drained", exp1_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_upsize.md
Name: stream_upsize

Overview:
- Width upsizer that packs RATIO narrow words from a valid/ready input stream into one wide output beat.
- Sits directly downstream of the team's buffering FIFO stage, consuming narrow words and feeding wide consumers.
- Packet boundaries are carried by a last flag. A short final beat is flushed early, with a lane-keep mask marking the filled lanes.

Parameters:
- DATA_WIDTH, 8, width of one input word (bits); must be ≥ 1.
- RATIO, 4, input words per output beat; must be ≥ 1.
- CNT_WIDTH, $clog2(RATIO)+1, lane counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- s_data_i  input  DATA_WIDTH  input word.
- s_last_i  input  1  input word is the final word of a packet.
- s_valid_i  input  1  input word valid.
- s_ready_o  output  1  block accepts the input word this cycle.
- m_data_o  output  DATA_WIDTH*RATIO  packed output beat; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- m_keep_o  output  RATIO  bit k = lane k holds a valid word.
- m_last_o  output  1  beat ends a packet.
- m_valid_o  output  1  output beat valid.
- m_ready_i  input  1  downstream accepts the beat.

Behaviour:
- Transfers:
  - Input transfer = s_valid_i & s_ready_o.
  - Output transfer = m_valid_o & m_ready_i.
- Reset (rst_n=0 at a clock edge):
  - Outputs: m_valid_o=0, m_last_o=0, m_keep_o=0, m_data_o=0.
  - Internal: lane counter=0, accumulator cleared.
  - A partial beat in progress is discarded, including on reset mid-packet.
  - While rst_n=0, s_ready_o=0.
- Ready rule: s_ready_o = ~m_valid_o | m_ready_i, registered-state only. There is no combinational path from s_valid_i/s_data_i/s_last_i to s_ready_o.
- Lane order: little-endian. The first accepted word of a beat goes to lane 0, the next to lane 1, and so on.
- Accumulation:
  - On an input transfer that does not complete a beat, the word is written into lane cnt of the accumulator, the matching keep bit is set, and cnt increments.
- Completion:
  - A beat completes on an input transfer where cnt==RATIO-1 or s_last_i=1.
  - On that edge, the output register loads {incoming word merged into accumulator}, keep with bits 0..cnt set, and m_last_o=s_last_i. m_valid_o goes to 1.
  - The accumulator and keep are cleared and cnt returns to 0.
  - Lanes above cnt in m_data_o are driven 0.
- Latency: m_valid_o rises 1 cycle after the completing input transfer.
- Output hold: while m_valid_o=1 and m_ready_i=0, m_data_o, m_keep_o and m_last_o are held stable.
- Simultaneous output transfer and completion: the output register reloads on the same edge, m_valid_o stays 1, and there is no bubble. Sustained throughput is 1 input word per cycle.
- Output transfer without completion: m_valid_o clears to 0. The payload fields may retain their old values.
- s_last_i with cnt=0: emits a single-lane beat, keep=...0001.
- RATIO=1: every accepted word becomes a beat with keep=1. This is a registered pass-through with 1-cycle latency.
- No state machine beyond the counter and the output-valid flag; the counter range is 0..RATIO-1.

Decomposition:
- Package stream_resize_pkg:
  - Function keep_mask(cnt, RATIO), returning the low cnt+1 bits set.
  - Shared valid/ready transfer naming constants used by all resize stages.
- No sub-module: the accumulator, counter and output register form one flat always_ff process plus an always_comb for ready and merge.

Test Plan:
1. Reset, then inputs 0x11, 0x22, 0x33, 0x44 (last on 0x44) with m_ready_i=1 → one beat: m_data_o=0x44332211, keep=0xF, last=1; m_valid_o high the cycle after 0x44 is accepted.
2. Inputs 0xA1, 0xA2 with last on 0xA2 → m_data_o=0x0000A2A1, keep=0x3, last=1. A single 0x5C with last → 0x0000005C, keep=0x1.
3. Continuous 8 words 0x01..0x08, no last, m_ready_i=1 → beats 0x04030201 then 0x08070605, last=0 on both, s_ready_o never deasserts.
4. Hold m_ready_i=0 after the first beat while feeding 0x09..0x0C → s_ready_o=0 and the first beat stays stable. Releasing m_ready_i → first beat transfers, then 0x0C0B0A09 is emitted.
5. Assert rst_n=0 after 2 of 4 words accepted, then send 0x31..0x34 → output 0x34333231, keep=0xF; no remnant of the pre-reset words.
6. RATIO=1, DATA_WIDTH=8: inputs 0x7E, 0x7F → beats 0x7E, 0x7F, keep=1, each 1 cycle after acceptance.
